// File: rtl/fifo_nibble_uart_tx.sv
// fifo_nibble_uart_tx
//   Drains words from the 4-bit circular FIFO and sends each one as an
//   asynchronous serial frame: start bit, DATA_W data bits (LSB first),
//   optional parity bit, stop bit. This block is the FIFO's only reader.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   enable      1 = allowed to start new frames (does not stop a frame in flight)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid in the cycle pop=1
//   pop         FIFO read strobe, combinational, only ever high in IDLE
//   tx          registered serial line, idle high
//   busy        high for every cycle of a frame (START..STOP)
//   word_count  frames fully sent, wraps 255 -> 0
module fifo_nibble_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              pop,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        word_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e            state_q,  state_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              parity_q, parity_d;
  logic [TW-1:0]     timer_q,  timer_d;
  logic [BW-1:0]     bit_q,    bit_d;
  logic              tx_q,     tx_d;
  logic              busy_q,   busy_d;
  logic [7:0]        wc_q,     wc_d;
  logic              last_tick;

  assign pop        = (state_q == S_IDLE) & enable & ~fifo_empty & ~reset;
  assign last_tick  = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign word_count = wc_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    wc_d     = wc_q;

    if (state_q != S_IDLE)
      timer_d = last_tick ? '0 : timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d  = fifo_data;
          parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
          timer_d  = '0;
          bit_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: if (last_tick) state_d = S_DATA;
      S_DATA: begin
        if (last_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: if (last_tick) state_d = S_STOP;
      S_STOP: begin
        if (last_tick) begin
          state_d = S_IDLE;
          wc_d    = wc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx and busy are derived from the *next* state so they are registered
  // (glitch-free) yet line up with the state they describe: tx falls the
  // cycle after pop, and busy covers exactly the frame's cycles.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      timer_q  <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wc_q     <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wc_q     <= wc_d;
    end
  end

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Bench for fifo_nibble_uart_tx. Two instances: defaults (even parity,
// 4 clocks/bit) and a no-parity 2 clocks/bit variant. Each has a queue-based
// FIFO model; words written are also pushed to a scoreboard queue, and a
// per-instance monitor checks every cycle against the frame expected from the
// scoreboard word.
module tb_fifo_nibble_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
  logic [3:0] fifo_data0 = '0, fifo_data1 = '0;
  logic       pop0, pop1, tx0, tx1, busy0, busy1;
  logic [7:0] wc0, wc1;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] fq0[$], fq1[$];   // FIFO contents seen by each DUT
  logic [3:0] eq0[$], eq1[$];   // scoreboard: words expected to be framed
  bit         mon_act [2];

  always #5 clk = ~clk;

  fifo_nibble_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty0),
    .fifo_data(fifo_data0), .pop(pop0), .tx(tx0), .busy(busy0), .word_count(wc0));

  fifo_nibble_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty1),
    .fifo_data(fifo_data1), .pop(pop1), .tx(tx1), .busy(busy1), .word_count(wc1));

  function automatic logic tx_of(int id);   return id != 0 ? tx1   : tx0;   endfunction
  function automatic logic busy_of(int id); return id != 0 ? busy1 : busy0; endfunction
  function automatic logic pop_of(int id);  return id != 0 ? pop1  : pop0;  endfunction
  function automatic logic [7:0] wc_of(int id); return id != 0 ? wc1 : wc0; endfunction
  function automatic int fsize(int id); return id != 0 ? fq1.size() : fq0.size(); endfunction

  // Frame symbol idx: 0 start, 1..4 data LSB first, then parity (instance 0
  // only, even), then stop.
  function automatic logic exp_bit(int id, logic [3:0] w, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 4) return w[idx-1];
    if (id == 0 && idx == 5) return ^w;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[dut%0d] @%0t got %0h expected %0h", name, id, $time, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty0 = (fq0.size() == 0);
    fifo_data0  = (fq0.size() != 0) ? fq0[0] : 4'h0;
    fifo_empty1 = (fq1.size() == 0);
    fifo_data1  = (fq1.size() != 0) ? fq1[0] : 4'h0;
  endtask

  task automatic push_word(input logic [3:0] w);
    fq0.push_back(w); eq0.push_back(w);
    fq1.push_back(w); eq1.push_back(w);
    refresh();
  endtask

  task automatic monitor(input int id);
    int cpb = (id != 0) ? 2 : 4;
    int F   = (id != 0) ? 12 : 28;
    int pos = 0;
    int wc  = 0;
    bit pend = 0;
    bit prev_rst = 0;
    logic [3:0] w = '0;
    forever begin
      @(negedge clk);
      // the DUT captured the FIFO head at the edge just passed
      if (pend) begin
        if (id != 0) void'(fq1.pop_front()); else void'(fq0.pop_front());
        refresh();
        pend = 0;
      end
      if (reset) begin
        chk("pop_in_reset", id, 32'(pop_of(id)), 0);
        if (prev_rst) begin
          chk("tx_reset", id, 32'(tx_of(id)), 1);
          chk("busy_reset", id, 32'(busy_of(id)), 0);
          chk("wc_reset", id, 32'(wc_of(id)), 0);
        end
        mon_act[id] = 0;
        wc = 0;
        prev_rst = 1;
        continue;
      end
      prev_rst = 0;
      chk("word_count", id, 32'(wc_of(id)), 32'(wc));
      if (mon_act[id]) begin
        chk("tx_frame", id, 32'(tx_of(id)), 32'(exp_bit(id, w, pos / cpb)));
        chk("busy_frame", id, 32'(busy_of(id)), 1);
        chk("pop_frame", id, 32'(pop_of(id)), 0);
        pos++;
        if (pos == F) begin
          mon_act[id] = 0;
          wc = (wc + 1) % 256;
        end
      end else begin
        chk("tx_idle", id, 32'(tx_of(id)), 1);
        chk("busy_idle", id, 32'(busy_of(id)), 0);
        chk("pop_idle", id, 32'(pop_of(id)), 32'(enable && fsize(id) > 0));
        if (pop_of(id)) begin
          if ((id != 0 ? eq1.size() : eq0.size()) == 0) begin
            chk("pop_no_word", id, 1, 0);
          end else begin
            w = (id != 0) ? eq1.pop_front() : eq0.pop_front();
            mon_act[id] = 1;
            pos = 0;
            pend = 1;
          end
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fq0.size() != 0 || fq1.size() != 0 || mon_act[0] || mon_act[1]) && n < budget) begin
      @(posedge clk); n++;
    end
    @(posedge clk); @(posedge clk); #2;
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout got %0d cycles expected < %0d", n, budget);
    end
  endtask

  task automatic wait_act(input int id, input int budget);
    int n = 0;
    while (!mon_act[id] && n < budget) begin @(posedge clk); n++; end
    #2;
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL frame_start_timeout[dut%0d] got %0d cycles expected < %0d", id, n, budget);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none

    // reset, then an empty FIFO for 50 cycles
    cycles(3);
    reset = 1'b0;
    cycles(50);

    // single word, then two back-to-back words
    push_word(4'hA);
    drain(200);
    push_word(4'h7);
    push_word(4'h1);
    drain(200);

    // reset in the middle of a frame, FIFO still holding a word afterwards
    push_word(4'h3);
    push_word(4'hC);
    wait_act(0, 50);
    cycles(9);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    drain(300);

    // enable dropped mid-frame with words waiting
    push_word(4'h9);
    push_word(4'h6);
    push_word(4'hF);
    wait_act(0, 50);
    enable = 1'b0;
    cycles(80);
    enable = 1'b1;
    drain(300);

    // randomized writes and enable toggling
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) push_word(4'($urandom));
      enable = ($urandom_range(0, 7) != 0);
      cycles(1);
    end
    enable = 1'b1;
    drain(3000);

    // 256 frames wrap word_count back to 0
    repeat (256) push_word(4'($urandom));
    drain(10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
